// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Shared constants and types for the fetch -> decode instruction buffer.
//   FQ_NOP_INSTR : word presented to decode while the queue is empty (sll $0,$0,0)
//   FQ_RESET_PC  : address fetch starts from after reset
//   fq_entry_t   : one buffered {pc, instr} pair as held in storage
package fetch_queue_pkg;

  localparam int          INSTR_W      = 32;
  localparam int          ADDR_W       = 32;
  localparam logic [31:0] FQ_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] FQ_RESET_PC  = 32'h0040_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Handshake bundle between fetch (enqueue side), decode (dequeue side) and
//   the fetch queue.
//   master : fetch/decode view - drives enq_*, flush, deq_ready
//   slave  : queue view        - drives enq_ready, deq_*, count
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               enq_valid;
  logic [ADDR_W-1:0]  enq_pc;
  logic [INSTR_W-1:0] enq_instr;
  logic               enq_ready;
  logic               flush;
  logic               deq_valid;
  logic               deq_ready;
  logic [ADDR_W-1:0]  deq_pc;
  logic [ADDR_W-1:0]  deq_pc_plus4;
  logic [INSTR_W-1:0] deq_instr;
  logic [CNT_W-1:0]   count;

  modport master (
    output enq_valid, enq_pc, enq_instr, flush, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_pc_plus4, deq_instr, count
  );

  modport slave (
    input  enq_valid, enq_pc, enq_instr, flush, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_pc_plus4, deq_instr, count
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem
//   DEPTH x WIDTH register array, one clocked write port, one async read port.
//   Storage is intentionally not reset; validity is tracked by the owner.
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational)
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   In-order buffer of {pc, instr} pairs between fetch and decode. enq_ready is
//   the PC advance enable and depends on registered occupancy only, so there is
//   no combinational path from decode back to the PC. A flush drops every entry
//   (wrong-path instructions) and rewinds both pointers.
//   i_clock   : clock, all state on posedge
//   i_reset_n : synchronous active-low reset, dominates flush and handshakes
//   fq        : fetch_queue_if slave port (enq_*, deq_*, flush, count)
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = FQ_NOP_INSTR
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  fetch_queue_if.slave  fq
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_enq_ready;
  logic             w_deq_valid;
  logic             w_enq_fire;
  logic             w_deq_fire;
  logic             w_clear;
  fq_entry_t        w_wr_entry;
  fq_entry_t        w_rd_entry;

  assign w_enq_ready = (r_count != FULL_CNT);
  assign w_deq_valid = (r_count != '0);
  assign w_enq_fire  = fq.enq_valid && w_enq_ready;
  assign w_deq_fire  = w_deq_valid && fq.deq_ready;
  // Reset and flush both rewind the queue; either one swallows same-cycle handshakes.
  assign w_clear     = !i_reset_n || fq.flush;

  assign w_wr_entry.pc    = fq.enq_pc;
  assign w_wr_entry.instr = fq.enq_instr;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .i_clk   (i_clock),
    .i_we    (w_enq_fire && !w_clear),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  // DEPTH is a power of two, so pointer wrap is plain modular increment.
  always_ff @(posedge i_clock) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq_fire) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq_fire) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_enq_fire && !w_deq_fire) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_deq_fire && !w_enq_fire) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign fq.enq_ready    = w_enq_ready;
  assign fq.deq_valid    = w_deq_valid;
  assign fq.count        = r_count;
  // Stale storage is masked while empty so decode sees a clean NOP at pc 0.
  assign fq.deq_pc       = w_deq_valid ? w_rd_entry.pc : '0;
  assign fq.deq_pc_plus4 = w_deq_valid ? (w_rd_entry.pc + 32'd4) : '0;
  assign fq.deq_instr    = w_deq_valid ? w_rd_entry.instr : NOP_INSTR;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic clk;
  logic rst_n;

  fetch_queue_if #(.DEPTH(DEPTH)) fq_if ();

  fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .fq        (fq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t mq[$];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          rst_n;
    bit          ev;
    logic [31:0] pc;
    logic [31:0] instr;
    bit          fl;
    bit          dr;
    int          e_count;
    bit          e_dv;
    bit          e_er;
    logic [31:0] e_pc;
    logic [31:0] e_p4;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mkv(bit r, bit ev, logic [31:0] pc, logic [31:0] ins, bit fl, bit dr,
                               int c, bit dv, bit er, logic [31:0] hpc, logic [31:0] hp4,
                               logic [31:0] hin);
    vec_t v;
    v.rst_n = r;  v.ev = ev;  v.pc = pc;  v.instr = ins;  v.fl = fl;  v.dr = dr;
    v.e_count = c;  v.e_dv = dv;  v.e_er = er;  v.e_pc = hpc;  v.e_p4 = hp4;  v.e_instr = hin;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: apply inputs, advance the reference queue, settle past the edge.
  task automatic cycle(input bit r, input bit ev, input logic [31:0] pc, input logic [31:0] ins,
                       input bit fl, input bit dr);
    bit m_er;
    bit m_dv;
    ent_t e;
    m_er = (mq.size() != DEPTH);
    m_dv = (mq.size() != 0);
    rst_n              = r;
    fq_if.enq_valid    = ev;
    fq_if.enq_pc       = pc;
    fq_if.enq_instr    = ins;
    fq_if.flush        = fl;
    fq_if.deq_ready    = dr;
    @(posedge clk);
    if (!r || fl) begin
      mq.delete();
    end else begin
      if (m_dv && dr) void'(mq.pop_front());
      if (ev && m_er) begin
        e.pc = pc;
        e.instr = ins;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(fq_if.count), 32'(n));
    chk({tag, ".deq_valid"}, 32'(fq_if.deq_valid), 32'(n != 0));
    chk({tag, ".enq_ready"}, 32'(fq_if.enq_ready), 32'(n != DEPTH));
    chk({tag, ".deq_pc"}, fq_if.deq_pc, (n != 0) ? mq[0].pc : 32'h0);
    chk({tag, ".deq_pc_plus4"}, fq_if.deq_pc_plus4, (n != 0) ? mq[0].pc + 32'd4 : 32'h0);
    chk({tag, ".deq_instr"}, fq_if.deq_instr, (n != 0) ? mq[0].instr : NOP);
  endtask

  vec_t tbl[13];

  initial begin
    logic [31:0] p;
    rst_n = 1'b0;
    fq_if.enq_valid = 1'b0;
    fq_if.enq_pc    = '0;
    fq_if.enq_instr = '0;
    fq_if.flush     = 1'b0;
    fq_if.deq_ready = 1'b0;

    // Reset with enq_valid held, fill to full, dropped 5th enq, drain, pc wrap.
    tbl[0]  = mkv(0, 1, 32'h0040_0000, 32'h1000_0000, 0, 0, 0, 0, 1, 32'h0, 32'h0, NOP);
    tbl[1]  = mkv(0, 1, 32'h0040_0000, 32'h1000_0000, 0, 0, 0, 0, 1, 32'h0, 32'h0, NOP);
    tbl[2]  = mkv(1, 1, 32'h0040_0000, 32'h1000_0000, 0, 0, 1, 1, 1, 32'h0040_0000, 32'h0040_0004, 32'h1000_0000);
    tbl[3]  = mkv(1, 1, 32'h0040_0004, 32'h1000_0001, 0, 0, 2, 1, 1, 32'h0040_0000, 32'h0040_0004, 32'h1000_0000);
    tbl[4]  = mkv(1, 1, 32'h0040_0008, 32'h1000_0002, 0, 0, 3, 1, 1, 32'h0040_0000, 32'h0040_0004, 32'h1000_0000);
    tbl[5]  = mkv(1, 1, 32'h0040_000C, 32'h1000_0003, 0, 0, 4, 1, 0, 32'h0040_0000, 32'h0040_0004, 32'h1000_0000);
    tbl[6]  = mkv(1, 1, 32'h0040_0010, 32'h1000_0004, 0, 0, 4, 1, 0, 32'h0040_0000, 32'h0040_0004, 32'h1000_0000);
    tbl[7]  = mkv(1, 0, 32'h0, 32'h0, 0, 1, 3, 1, 1, 32'h0040_0004, 32'h0040_0008, 32'h1000_0001);
    tbl[8]  = mkv(1, 0, 32'h0, 32'h0, 0, 1, 2, 1, 1, 32'h0040_0008, 32'h0040_000C, 32'h1000_0002);
    tbl[9]  = mkv(1, 0, 32'h0, 32'h0, 0, 1, 1, 1, 1, 32'h0040_000C, 32'h0040_0010, 32'h1000_0003);
    tbl[10] = mkv(1, 0, 32'h0, 32'h0, 0, 1, 0, 0, 1, 32'h0, 32'h0, NOP);
    tbl[11] = mkv(1, 1, 32'hFFFF_FFFC, 32'hB000_0000, 0, 0, 1, 1, 1, 32'hFFFF_FFFC, 32'h0000_0000, 32'hB000_0000);
    tbl[12] = mkv(1, 0, 32'h0, 32'h0, 0, 1, 0, 0, 1, 32'h0, 32'h0, NOP);

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].rst_n, tbl[i].ev, tbl[i].pc, tbl[i].instr, tbl[i].fl, tbl[i].dr);
      chk($sformatf("vec%0d.count", i), 32'(fq_if.count), 32'(tbl[i].e_count));
      chk($sformatf("vec%0d.deq_valid", i), 32'(fq_if.deq_valid), 32'(tbl[i].e_dv));
      chk($sformatf("vec%0d.enq_ready", i), 32'(fq_if.enq_ready), 32'(tbl[i].e_er));
      chk($sformatf("vec%0d.deq_pc", i), fq_if.deq_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d.deq_pc_plus4", i), fq_if.deq_pc_plus4, tbl[i].e_p4);
      chk($sformatf("vec%0d.deq_instr", i), fq_if.deq_instr, tbl[i].e_instr);
    end

    // Streaming: one in, one out per cycle, pointers wrap several times.
    for (int i = 0; i < 20; i++) begin
      p = 32'h0040_0000 + 32'(4 * i);
      cycle(1, 1, p, 32'h2000_0000 + 32'(i), 0, 1);
      chk($sformatf("stream%0d.count", i), 32'(fq_if.count), 32'd1);
      chk($sformatf("stream%0d.deq_pc", i), fq_if.deq_pc, p);
      chk($sformatf("stream%0d.deq_instr", i), fq_if.deq_instr, 32'h2000_0000 + 32'(i));
    end
    cycle(1, 0, 32'h0, 32'h0, 0, 1);
    check_model("stream_drain");

    // Flush with a same-cycle enq: the wrong-path enq is dropped.
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h0040_0000 + 32'(4 * i), 32'h3000_0000 + 32'(i), 0, 0);
    chk("flush.pre_count", 32'(fq_if.count), 32'd3);
    cycle(1, 1, 32'h0040_0100, 32'h3000_0100, 1, 0);
    chk("flush.count", 32'(fq_if.count), 32'd0);
    chk("flush.deq_valid", 32'(fq_if.deq_valid), 32'd0);
    chk("flush.deq_instr", fq_if.deq_instr, NOP);
    cycle(1, 1, 32'h0040_0200, 32'h3000_0200, 0, 0);
    chk("flush.next_head", fq_if.deq_pc, 32'h0040_0200);
    chk("flush.next_count", 32'(fq_if.count), 32'd1);
    cycle(1, 0, 32'h0, 32'h0, 0, 1);

    // Full with deq and enq in the same cycle: only the dequeue happens.
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'h0040_0300 + 32'(4 * i), 32'h4000_0000 + 32'(i), 0, 0);
    chk("fulldeq.pre_ready", 32'(fq_if.enq_ready), 32'd0);
    cycle(1, 1, 32'h0040_0400, 32'h4000_0400, 0, 1);
    chk("fulldeq.count", 32'(fq_if.count), 32'd3);
    chk("fulldeq.enq_ready", 32'(fq_if.enq_ready), 32'd1);
    chk("fulldeq.head", fq_if.deq_pc, 32'h0040_0304);
    cycle(1, 0, 32'h0, 32'h0, 0, 1);
    chk("fulldeq.head2", fq_if.deq_pc, 32'h0040_0308);
    cycle(1, 0, 32'h0, 32'h0, 0, 1);
    chk("fulldeq.head3", fq_if.deq_pc, 32'h0040_030C);
    cycle(1, 0, 32'h0, 32'h0, 0, 1);
    chk("fulldeq.empty", 32'(fq_if.count), 32'd0);

    // Reset in the middle of operation behaves like a flush.
    cycle(1, 1, 32'h0040_0500, 32'h5000_0000, 0, 0);
    cycle(1, 1, 32'h0040_0504, 32'h5000_0001, 0, 0);
    cycle(0, 1, 32'h0040_0508, 32'h5000_0002, 1, 1);
    check_model("midreset");

    // Randomized traffic against the queue model; early phase biased toward full.
    for (int i = 0; i < 600; i++) begin
      bit r;
      bit ev;
      bit fl;
      bit dr;
      r  = ($urandom_range(0, 99) != 0);
      fl = ($urandom_range(0, 24) == 0);
      ev = ($urandom_range(0, 3) != 0);
      dr = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      cycle(r, ev, $urandom & 32'hFFFF_FFFC, $urandom, fl, dr);
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
